vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator.
- Produces horizontal/vertical counters, sync pulses, active-video flag, pixel coordinates and line/frame strobes for the snake-game renderer.
- Runs on the system clock, qualified by a pixel-enable tick (no derived clock).
- H and V counters advance in the same tick: no dead cycle at line wrap.
- Sits between the pixel-tick divider and the game/render logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, hsync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level
- CW, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_en  in  1  pixel tick; counters advance only when high
- h_count  out  CW  horizontal position, 0..H_TOTAL-1
- v_count  out  CW  vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per HS_POL
- vsync  out  1  vertical sync, polarity per VS_POL
- active  out  1  high while h_count<H_ACTIVE and v_count<V_ACTIVE
- x  out  CW  h_count when active, else 0
- y  out  CW  v_count when active, else 0
- line_start  out  1  pix_en & h_count==0
- frame_start  out  1  pix_en & h_count==0 & v_count==0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default). V_TOTAL defined likewise (525 default).
- h_count and v_count are the only state registers. All other outputs are decoded combinationally from them (line_start and frame_start also use pix_en).
- Reset:
  - rst has priority over pix_en; next edge gives h_count=0, v_count=0.
  - hsync = !HS_POL, vsync = !VS_POL, active=1, x=y=0.
  - line_start and frame_start follow pix_en.
- Tick with pix_en=1:
  - If h_count<H_TOTAL-1: h_count+1.
  - Else: h_count=0, and on the same edge v_count+1, or 0 when v_count==V_TOTAL-1.
- pix_en=0: both counters hold; strobes low.
- hsync asserted for H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC (656..751 default).
- vsync asserted for V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC (490..491 default). vsync is keyed on v_count only, so it changes at line start.
- Strobes last one clk cycle per qualifying tick. frame_start implies line_start.
- Frame period is exactly H_TOTAL*V_TOTAL pix_en ticks (420000 default), regardless of gaps in pix_en.
- Reset mid-frame: counters return to 0,0 on the next edge. No partial-line recovery.
- Elaboration must fail when CW is too narrow for H_TOTAL-1 or V_TOTAL-1, or when any porch/sync parameter is 0.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [15:0], a registered count of completed frames.
  - Increments on the edge where both counters wrap to 0,0; wraps 16'hFFFF->0.
  - Reset value 0.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Package vga_pkg holds:
  - default timing constants (640x480@60);
  - typedef coord_t = logic [CW-1:0] at the default CW;
  - function total(active, fp, sync, bp).
- Sub-module vga_axis_counter, instantiated twice (H, V).
  - Parameters: TOTAL, width.
  - Ports: clk, rst, inc, count, wrap.
  - wrap = inc & count==TOTAL-1.
  - H instance: inc = pix_en. V instance: inc = H wrap.

Test Plan:
1. Reset then pix_en held high for 800 clks -> h_count 0..799 then 0; v_count 0->1 on the same edge h wraps; line_start high at clk 0 and clk 800.
2. pix_en high every clk for 420000 clks -> exactly one frame_start (at clk 0), then frame_start again at clk 420000; v_count never exceeds 524.
3. Scan one line -> hsync low only for h_count 656..751, active low from h_count 640; x=0 outside active; at h=639, v=479 x=639, y=479.
4. pix_en toggling 1-of-4 clks -> counts advance once per 4 clks; no strobe while pix_en=0; full frame = 1,680,000 clks.
5. Assert rst at h=300, v=200 for one clk -> next cycle h=0, v=0, hsync and vsync inactive (high); with pix_en=1, frame_start high in that cycle.
6. With VGA_TIMING_FRAME_CNT_EN, run 3 frames -> frame_cnt 0,1,2,3 changing on each 0,0 wrap. Override HS_POL=1 and H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88, CW=11 -> hsync high for h 840..967, h wraps at 1055.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers.
// Defaults describe 640x480@60 on a 25.175 MHz-class pixel tick.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int CW_DEF       = 10;

    typedef logic [CW_DEF-1:0] coord_t;

    function automatic int total(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on each inc, flags the wrap.
// wrap is combinational so the next axis can advance on the same edge.
module vga_axis_counter #(
    parameter int TOTAL = 800,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

    if (TOTAL < 2 || ((TOTAL - 1) >> WIDTH) != 0) begin : g_bad_width
        $error("vga_axis_counter: WIDTH too narrow for TOTAL-1");
    end

    assign wrap = inc && (count == LAST);

    // Position register: clear on reset, step or wrap on each increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: H/V counters plus decoded syncs, blanking, strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit completed-frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_ACT = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0)
    begin : g_bad_timing
        $error("vga_timing_gen: zero-length timing segment");
    end

    if (((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0)
    begin : g_bad_cw
        $error("vga_timing_gen: CW too narrow for H/V totals");
    end

    logic h_wrap;
    logic v_wrap;
    logic in_hs;
    logic in_vs;

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .WIDTH (CW)
    ) u_h (
        .clk   (clk),
        .rst   (rst),
        .inc   (pix_en),
        .count (h_count),
        .wrap  (h_wrap)
    );

    // V steps on the very tick H wraps, so there is no dead cycle.
    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .WIDTH (CW)
    ) u_v (
        .clk   (clk),
        .rst   (rst),
        .inc   (h_wrap),
        .count (v_count),
        .wrap  (v_wrap)
    );

    assign in_hs = (h_count >= HS_BEG) && (h_count < HS_END);
    assign in_vs = (v_count >= VS_BEG) && (v_count < VS_END);

    assign hsync  = in_hs ? HS_POL : !HS_POL;
    assign vsync  = in_vs ? VS_POL : !VS_POL;
    assign active = (h_count < H_ACT) && (v_count < V_ACT);

    assign x = active ? h_count : '0;
    assign y = active ? v_count : '0;

    assign line_start  = pix_en && (h_count == '0);
    assign frame_start = line_start && (v_count == '0);

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Completed-frame count, bumped when both axes wrap together.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (v_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`else
    logic v_wrap_unused;
    assign v_wrap_unused = v_wrap;
`endif

endmodule
